// File: rtl/adc_spi_responder_if.sv
// Serial pins of the AD7928-style link between the ADC driver (master) and
// the adc_spi_responder (slave).
interface adc_spi_responder_if;
   logic adc_cs_n;
   logic adc_sclk;
   logic adc_din;
   logic adc_dout;

   modport master (output adc_cs_n, output adc_sclk, output adc_din, input adc_dout);
   modport slave  (input adc_cs_n, input adc_sclk, input adc_din, output adc_dout);
endinterface

// File: rtl/adc_spi_responder.sv
// AD7928-compatible SPI responder: oversampled CS_N/SCLK/DIN, 12-bit control decode,
// address-tagged 12-bit sample out. Optional ADC_RESP_CODING_EN enables two's-complement output.
module adc_spi_responder #(
   parameter int SYNC_STAGES = 2
) (
   input  logic                clock,
   input  logic                reset_n,
   adc_spi_responder_if.slave  spi,
   input  logic [95:0]         sample_in,
   output logic [2:0]          cur_addr,
   output logic                range_bit,
   output logic                coding_bit,
   output logic [11:0]         ctrl_word,
   output logic                ctrl_valid,
   output logic                frame_err,
   output logic [15:0]         frame_count
);
   localparam int S = SYNC_STAGES;

   typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

   state_t         state_q, state_d;
   logic [S-1:0]   cs_sync_q, cs_sync_d;
   logic [S-1:0]   sclk_sync_q, sclk_sync_d;
   logic [S-1:0]   din_sync_q, din_sync_d;
   logic [S-1:0]   prime_q, prime_d;
   logic           cs_dly_q, cs_dly_d;
   logic           sclk_dly_q, sclk_dly_d;
   logic           armed_q, armed_d;
   logic [15:0]    tx_sr_q, tx_sr_d;
   logic [11:0]    rx_sr_q, rx_sr_d;
   logic [4:0]     rise_cnt_q, rise_cnt_d;
   logic [4:0]     fall_cnt_q, fall_cnt_d;
   logic           overrun_q, overrun_d;
   logic           dout_q, dout_d;
   logic [2:0]     cur_addr_q, cur_addr_d;
   logic           range_q, range_d;
   logic           coding_q, coding_d;
   logic [11:0]    ctrl_word_q, ctrl_word_d;
   logic           ctrl_valid_q, ctrl_valid_d;
   logic           frame_err_q, frame_err_d;
   logic [15:0]    frame_count_q, frame_count_d;

   logic           cs_s, sclk_s, din_s;
   logic           cs_fall, cs_rise, sclk_rise, sclk_fall;
   logic           good_frame;
   logic [6:0]     sample_base;
   logic [11:0]    raw_sample, tx_data;

   always_comb begin
      cs_sync_d   = {cs_sync_q[S-2:0], spi.adc_cs_n};
      sclk_sync_d = {sclk_sync_q[S-2:0], spi.adc_sclk};
      din_sync_d  = {din_sync_q[S-2:0], spi.adc_din};
      prime_d     = {prime_q[S-2:0], 1'b1};
      cs_s        = cs_sync_q[S-1];
      sclk_s      = sclk_sync_q[S-1];
      din_s       = din_sync_q[S-1];
      cs_dly_d    = cs_s;
      sclk_dly_d  = sclk_s;
      // A CS fall only counts once CS has been seen high through a chain refilled after reset,
      // so a frame interrupted by reset is ignored until the master starts a new one.
      armed_d     = armed_q | (prime_q[S-1] & cs_s);
      cs_fall     = armed_q & cs_dly_q & ~cs_s;
      cs_rise     = ~cs_dly_q & cs_s;
      sclk_rise   = ~sclk_dly_q & sclk_s;
      sclk_fall   = sclk_dly_q & ~sclk_s;
   end

   assign sample_base = 7'(cur_addr_q) * 7'd12;
   assign raw_sample  = sample_in[sample_base +: 12];
`ifdef ADC_RESP_CODING_EN
   assign tx_data     = coding_q ? raw_sample : (raw_sample ^ 12'h800);
`else
   assign tx_data     = raw_sample;
`endif

   assign good_frame = (rise_cnt_q == 5'd16) && (fall_cnt_q >= 5'd12) && !overrun_q;

   always_comb begin
      state_d       = state_q;
      tx_sr_d       = tx_sr_q;
      rx_sr_d       = rx_sr_q;
      rise_cnt_d    = rise_cnt_q;
      fall_cnt_d    = fall_cnt_q;
      overrun_d     = overrun_q;
      dout_d        = dout_q;
      cur_addr_d    = cur_addr_q;
      range_d       = range_q;
      coding_d      = coding_q;
      ctrl_word_d   = ctrl_word_q;
      ctrl_valid_d  = 1'b0;
      frame_err_d   = 1'b0;
      frame_count_d = frame_count_q;

      if ((state_q == SHIFT || state_q == HOLD) && cs_rise) begin
         state_d = IDLE;
         dout_d  = 1'b0;
         if (good_frame) begin
            ctrl_word_d   = rx_sr_q;
            ctrl_valid_d  = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
            if (rx_sr_q[11]) begin
               cur_addr_d = rx_sr_q[8:6];
               range_d    = rx_sr_q[1];
               coding_d   = rx_sr_q[0];
            end
         end else begin
            frame_err_d = 1'b1;
         end
      end else begin
         case (state_q)
            IDLE: begin
               dout_d = 1'b0;
               if (cs_fall) begin
                  state_d    = SHIFT;
                  tx_sr_d    = {1'b0, cur_addr_q, tx_data};
                  rise_cnt_d = 5'd0;
                  fall_cnt_d = 5'd0;
                  overrun_d  = 1'b0;
                  dout_d     = 1'b0;
               end
            end
            SHIFT: begin
               if (sclk_rise) begin
                  rise_cnt_d = rise_cnt_q + 5'd1;
                  tx_sr_d    = {tx_sr_q[14:0], 1'b0};
                  dout_d     = tx_sr_q[14];
                  if (rise_cnt_q == 5'd15) begin
                     state_d = HOLD;
                     dout_d  = 1'b0;
                  end
               end
               if (sclk_fall) begin
                  if (fall_cnt_q < 5'd12) rx_sr_d = {rx_sr_q[10:0], din_s};
                  if (fall_cnt_q < 5'd16) fall_cnt_d = fall_cnt_q + 5'd1;
               end
            end
            HOLD: begin
               dout_d = 1'b0;
               if (sclk_rise) overrun_d = 1'b1;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cs_sync_q     <= '1;
         sclk_sync_q   <= '1;
         din_sync_q    <= '0;
         prime_q       <= '0;
         cs_dly_q      <= 1'b1;
         sclk_dly_q    <= 1'b1;
         armed_q       <= 1'b0;
         state_q       <= IDLE;
         tx_sr_q       <= '0;
         rx_sr_q       <= '0;
         rise_cnt_q    <= '0;
         fall_cnt_q    <= '0;
         overrun_q     <= 1'b0;
         dout_q        <= 1'b0;
         cur_addr_q    <= '0;
         range_q       <= 1'b0;
         coding_q      <= 1'b1;
         ctrl_word_q   <= '0;
         ctrl_valid_q  <= 1'b0;
         frame_err_q   <= 1'b0;
         frame_count_q <= '0;
      end else begin
         cs_sync_q     <= cs_sync_d;
         sclk_sync_q   <= sclk_sync_d;
         din_sync_q    <= din_sync_d;
         prime_q       <= prime_d;
         cs_dly_q      <= cs_dly_d;
         sclk_dly_q    <= sclk_dly_d;
         armed_q       <= armed_d;
         state_q       <= state_d;
         tx_sr_q       <= tx_sr_d;
         rx_sr_q       <= rx_sr_d;
         rise_cnt_q    <= rise_cnt_d;
         fall_cnt_q    <= fall_cnt_d;
         overrun_q     <= overrun_d;
         dout_q        <= dout_d;
         cur_addr_q    <= cur_addr_d;
         range_q       <= range_d;
         coding_q      <= coding_d;
         ctrl_word_q   <= ctrl_word_d;
         ctrl_valid_q  <= ctrl_valid_d;
         frame_err_q   <= frame_err_d;
         frame_count_q <= frame_count_d;
      end
   end

   assign spi.adc_dout = dout_q;
   assign cur_addr     = cur_addr_q;
   assign range_bit    = range_q;
   assign coding_bit   = coding_q;
   assign ctrl_word    = ctrl_word_q;
   assign ctrl_valid   = ctrl_valid_q;
   assign frame_err    = frame_err_q;
   assign frame_count  = frame_count_q;
endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder: bit-banged SPI master plus a frame-level model
// that predicts every pulse and committed register cycle by cycle.
module tb_adc_spi_responder;
   localparam int S  = 2;
   localparam int PH = S + 4;

   logic        clock = 1'b0;
   logic        reset_n = 1'b1;
   logic [95:0] sample_in;
   logic [2:0]  cur_addr;
   logic        range_bit, coding_bit, ctrl_valid, frame_err;
   logic [11:0] ctrl_word;
   logic [15:0] frame_count;

   adc_spi_responder_if spi ();

   adc_spi_responder #(.SYNC_STAGES(S)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .spi         (spi),
      .sample_in   (sample_in),
      .cur_addr    (cur_addr),
      .range_bit   (range_bit),
      .coding_bit  (coding_bit),
      .ctrl_word   (ctrl_word),
      .ctrl_valid  (ctrl_valid),
      .frame_err   (frame_err),
      .frame_count (frame_count)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Frame-level model: each finished frame becomes an event due S+2 negedges after CS rise.
   typedef struct {
      int          due;
      bit          good;
      logic [11:0] word;
   } ev_t;

   ev_t         evq[$];
   int          cyc = 0;
   logic [2:0]  m_addr = 3'd0;
   logic        m_range = 1'b0;
   logic        m_coding = 1'b1;
   logic [11:0] m_word = 12'd0;
   logic [15:0] m_count = 16'd0;
   logic        m_v, m_e;
   ev_t         m_ev;

   always @(negedge clock) begin
      cyc++;
      m_v = 1'b0;
      m_e = 1'b0;
      if (!reset_n) begin
         m_addr = 3'd0; m_range = 1'b0; m_coding = 1'b1; m_word = 12'd0; m_count = 16'd0;
         evq.delete();
         chk("dout_in_reset", 32'(spi.adc_dout), 32'd0);
      end else if (evq.size() > 0 && evq[0].due == cyc) begin
         m_ev = evq.pop_front();
         if (m_ev.good) begin
            m_v = 1'b1;
            m_word = m_ev.word;
            m_count = m_count + 16'd1;
            if (m_ev.word[11]) begin
               m_addr = m_ev.word[8:6];
               m_range = m_ev.word[1];
               m_coding = m_ev.word[0];
            end
         end else begin
            m_e = 1'b1;
         end
      end
      chk("ctrl_valid", 32'(ctrl_valid), 32'(m_v));
      chk("frame_err", 32'(frame_err), 32'(m_e));
      chk("cur_addr", 32'(cur_addr), 32'(m_addr));
      chk("range_bit", 32'(range_bit), 32'(m_range));
      chk("coding_bit", 32'(coding_bit), 32'(m_coding));
      chk("ctrl_word", 32'(ctrl_word), 32'(m_word));
      chk("frame_count", 32'(frame_count), 32'(m_count));
   end

   function automatic logic [15:0] model_tx();
      logic [11:0] d;
      d = sample_in[int'(m_addr)*12 +: 12];
`ifdef ADC_RESP_CODING_EN
      if (!m_coding) d = d ^ 12'h800;
`endif
      return {1'b0, m_addr, d};
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // n SCLK cycles; rst_at >= 0 pulses reset_n before that cycle's falling edge.
   task automatic frame(input logic [11:0] w, input int n, input int rst_at, input bit mid,
                        output logic [16:0] rx);
      logic [15:0] dw;
      int c0;
      dw = {w, 4'h0};
      rx = '0;
      spi.adc_din = dw[15];
      spi.adc_cs_n = 1'b0;
      tick(PH);
      for (int i = 0; i < n; i++) begin
         if (i == rst_at) begin
            reset_n = 1'b0;
            tick(1);
            chk("rst_cur_addr", 32'(cur_addr), 32'd0);
            chk("rst_coding", 32'(coding_bit), 32'd1);
            chk("rst_count", 32'(frame_count), 32'd0);
            chk("rst_dout", 32'(spi.adc_dout), 32'd0);
            tick(2);
            reset_n = 1'b1;
            tick(1);
         end
         if (mid && i == 4) sample_in = ~sample_in;
         rx = {rx[15:0], spi.adc_dout};
         spi.adc_sclk = 1'b0;
         tick(PH);
         spi.adc_sclk = 1'b1;
         if (i < 15) spi.adc_din = dw[14-i];
         else spi.adc_din = 1'b0;
         tick(PH);
      end
      c0 = cyc;
      spi.adc_cs_n = 1'b1;
      if (rst_at < 0) evq.push_back('{c0 + S + 2, (n == 16), w});
      tick(3 * PH);
   endtask

   logic [16:0] rx;
   logic [15:0] exp_tx;
   logic [95:0] saved;

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      spi.adc_cs_n = 1'b1;
      spi.adc_sclk = 1'b1;
      spi.adc_din  = 1'b0;
      sample_in = {12'h777, 12'h666, 12'h456, 12'h345, 12'h123, 12'h5A5, 12'h111, 12'hABC};
      #1 reset_n = 1'b0;
      tick(3);
      chk("reset_ctrl_word", 32'(ctrl_word), 32'h0);
      chk("reset_range", 32'(range_bit), 32'd0);
      chk("reset_coding", 32'(coding_bit), 32'd1);
      chk("reset_count", 32'(frame_count), 32'd0);
      reset_n = 1'b1;
      tick(10);

      exp_tx = model_tx();
      frame(12'h8C3, 16, -1, 1'b0, rx);
      chk("f1_rx_model", 32'(rx[15:0]), 32'(exp_tx));
      chk("f1_rx", 32'(rx[15:0]), 32'h0ABC);
      chk("f1_ctrl_word", 32'(ctrl_word), 32'h8C3);
      chk("f1_cur_addr", 32'(cur_addr), 32'd3);
      chk("f1_count", 32'(frame_count), 32'd1);

      saved = sample_in;
      exp_tx = model_tx();
      frame(12'h7C2, 16, -1, 1'b1, rx);
      sample_in = saved;
      chk("f2_rx_model", 32'(rx[15:0]), 32'(exp_tx));
      chk("f2_rx", 32'(rx[15:0]), 32'h3123);
      chk("f2_cur_addr", 32'(cur_addr), 32'd3);
      chk("f2_count", 32'(frame_count), 32'd2);

      frame(12'h8C3, 9, -1, 1'b0, rx);
      chk("f3_ctrl_word", 32'(ctrl_word), 32'h7C2);
      chk("f3_cur_addr", 32'(cur_addr), 32'd3);
      chk("f3_count", 32'(frame_count), 32'd2);

      exp_tx = model_tx();
      frame(12'h883, 16, -1, 1'b0, rx);
      chk("f4_rx_model", 32'(rx[15:0]), 32'(exp_tx));
      chk("f4_rx", 32'(rx[15:0]), 32'h3123);
      chk("f4_cur_addr", 32'(cur_addr), 32'd2);
      chk("f4_range", 32'(range_bit), 32'd1);

      exp_tx = model_tx();
      frame(12'hFFF, 17, -1, 1'b0, rx);
      chk("f5_rx_model", 32'(rx[16:1]), 32'(exp_tx));
      chk("f5_rx", 32'(rx[16:1]), 32'h25A5);
      chk("f5_bit17", 32'(rx[0]), 32'd0);
      chk("f5_cur_addr", 32'(cur_addr), 32'd2);
      chk("f5_ctrl_word", 32'(ctrl_word), 32'h883);
      chk("f5_count", 32'(frame_count), 32'd3);

      frame(12'h800, 16, -1, 1'b0, rx);
      chk("f6_rx", 32'(rx[15:0]), 32'h25A5);
      chk("f6_coding", 32'(coding_bit), 32'd0);
      chk("f6_cur_addr", 32'(cur_addr), 32'd0);

      sample_in[11:0] = 12'h000;
      exp_tx = model_tx();
      frame(12'h000, 16, -1, 1'b0, rx);
      chk("f7_rx_model", 32'(rx[15:0]), 32'(exp_tx));
`ifdef ADC_RESP_CODING_EN
      chk("f7_rx", 32'(rx[15:0]), 32'h0800);
`else
      chk("f7_rx", 32'(rx[15:0]), 32'h0000);
`endif
      chk("f7_count", 32'(frame_count), 32'd5);

      frame(12'h8C3, 16, 7, 1'b0, rx);
      chk("f8_count", 32'(frame_count), 32'd0);
      chk("f8_cur_addr", 32'(cur_addr), 32'd0);
      chk("f8_ctrl_word", 32'(ctrl_word), 32'h0);

      sample_in[11:0] = 12'hABC;
      exp_tx = model_tx();
      frame(12'h000, 16, -1, 1'b0, rx);
      chk("f9_rx_model", 32'(rx[15:0]), 32'(exp_tx));
      chk("f9_rx", 32'(rx[15:0]), 32'h0ABC);
      chk("f9_count", 32'(frame_count), 32'd1);

      chk("events_drained", 32'(evq.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
